// File: rtl/univ_dff_reg.sv
// univ_dff_reg: WIDTH-bit universal shift/load register with complementary outputs and shift-frame counter
module univ_dff_reg #(
  parameter int          WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0,
  parameter int          CNT_W     = $clog2(WIDTH+1)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);
  logic [WIDTH-1:0] r_q, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done, w_shift, w_load, w_wrap;
  always_comb begin
    w_shift = en & (mode[0] ^ mode[1]);
    w_load  = en & (mode == 2'b11);
    w_wrap  = r_cnt == CNT_W'(WIDTH-1);
    w_next  = !en            ? r_q :
              mode == 2'b01  ? {r_q[WIDTH-2:0], sin_l} :
              mode == 2'b10  ? {sin_r, r_q[WIDTH-1:1]} :
              mode == 2'b11  ? d : r_q;
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_q    <= RV;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (sync_clr) begin
      r_q    <= RV;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_next;
      r_cnt  <= w_load ? '0 : !w_shift ? r_cnt : w_wrap ? '0 : r_cnt + 1'b1;
      r_done <= w_shift & w_wrap;
    end
  end
  assign q          = r_q;
  assign qbar       = ~r_q;
  assign sout_l     = r_q[WIDTH-1];
  assign sout_r     = r_q[0];
  assign shift_cnt  = r_cnt;
  assign frame_done = r_done;
endmodule

// File: tb/tb_univ_dff_reg.sv
// tb_univ_dff_reg: randomized scoreboard bench for univ_dff_reg (RESET_VAL 0 and 8'h3C instances side by side)
module tb_univ_dff_reg;
  logic       clock = 0, clear = 1, en = 0, sync_clr = 0, sin_l = 0, sin_r = 0;
  logic [1:0] mode = 0;
  logic [7:0] d = 0;
  logic [7:0] oq[2], oqb[2];
  logic       osl[2], osr[2], ofd[2];
  logic [3:0] oc[2];
  typedef struct packed {
    logic [1:0][7:0] q;
    logic [1:0][3:0] c;
    logic [1:0]      f;
  } exp_t;
  exp_t sb[$];
  int mq[2], mn[2];
  int rv[2] = '{0, 'h3C};
  int n_cmp = 0, n_bad = 0;

  univ_dff_reg #(.WIDTH(8), .RESET_VAL(0)) dut0 (
    .clock(clock), .clear(clear), .en(en), .sync_clr(sync_clr), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(oq[0]), .qbar(oqb[0]), .sout_l(osl[0]), .sout_r(osr[0]),
    .shift_cnt(oc[0]), .frame_done(ofd[0]));
  univ_dff_reg #(.WIDTH(8), .RESET_VAL('h3C)) dut1 (
    .clock(clock), .clear(clear), .en(en), .sync_clr(sync_clr), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(oq[1]), .qbar(oqb[1]), .sout_l(osl[1]), .sout_r(osr[1]),
    .shift_cnt(oc[1]), .frame_done(ofd[1]));

  always #10 clock = ~clock;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(exp_t e, string tag);
    logic [7:0] nq;
    for (int k = 0; k < 2; k++) begin
      nq = ~e.q[k];
      chk($sformatf("%s_q%0d", tag, k), 32'(oq[k]), 32'(e.q[k]));
      chk($sformatf("%s_qbar%0d", tag, k), 32'(oqb[k]), 32'(nq));
      chk($sformatf("%s_sout_l%0d", tag, k), 32'(osl[k]), 32'(e.q[k][7]));
      chk($sformatf("%s_sout_r%0d", tag, k), 32'(osr[k]), 32'(e.q[k][0]));
      chk($sformatf("%s_cnt%0d", tag, k), 32'(oc[k]), 32'(e.c[k]));
      chk($sformatf("%s_done%0d", tag, k), 32'(ofd[k]), 32'(e.f[k]));
    end
  endtask

  function automatic exp_t cur();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.q[k] = 8'(mq[k]);
      e.c[k] = 4'(mn[k] % 8);
      e.f[k] = 1'b0;
    end
    return e;
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = rv[k];
      mn[k] = 0;
    end
  endtask

  // Model counts shifts since the last load/clear; the frame boundary is every 8th shift.
  task automatic apply(bit e_, bit s_, logic [1:0] m_, logic [7:0] d_, bit l_, bit r_);
    exp_t e;
    en = e_; sync_clr = s_; mode = m_; d = d_; sin_l = l_; sin_r = r_;
    e = cur();
    for (int k = 0; k < 2; k++) begin
      if (s_) begin
        mq[k] = rv[k]; mn[k] = 0;
      end else if (e_ && m_ != 0) begin
        if (m_ == 3) begin
          mq[k] = d_; mn[k] = 0;
        end else begin
          mq[k] = (m_ == 1) ? (((mq[k] << 1) | int'(l_)) & 'hFF) : ((mq[k] >> 1) | (int'(r_) << 7));
          mn[k]++;
          e.f[k] = (mn[k] % 8 == 0);
        end
      end
      e.q[k] = 8'(mq[k]);
      e.c[k] = 4'(mn[k] % 8);
    end
    sb.push_back(e);
  endtask

  task automatic step(bit e_, bit s_, logic [1:0] m_, logic [7:0] d_, bit l_, bit r_);
    @(negedge clock);
    apply(e_, s_, m_, d_, l_, r_);
  endtask

  task automatic aclr_pulse();
    @(negedge clock);
    en = 0; sync_clr = 0;
    #1 clear = 1;
    #1 mreset();
    check_outs(cur(), "aclr");
    #3 clear = 0;
    apply(0, 0, 2'b00, d, sin_l, sin_r);
  endtask

  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) check_outs(sb.pop_front(), "edge");
  end

  initial begin
    clear = 1; en = 1; mode = 3; d = 8'hFF;
    mreset();
    repeat (3) begin
      @(posedge clock);
      #2 check_outs(cur(), "rst");
    end
    @(negedge clock);
    clear = 0;
    apply(1, 0, 3, 8'hFF, 0, 0);
    step(1, 0, 3, 8'hA5, 0, 0);
    repeat (4) step(1, 0, 0, 8'h00, 0, 0);
    step(0, 0, 3, 8'h00, 0, 0);
    step(1, 0, 3, 8'h81, 0, 0);
    repeat (8) step(1, 0, 1, 8'h00, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    step(1, 0, 3, 8'h0F, 0, 0);
    repeat (3) step(1, 0, 2, 8'h00, 0, 1);
    repeat (2) step(0, 0, 1, 8'h00, 0, 1);
    repeat (5) step(1, 0, 1, 8'h00, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    step(1, 0, 3, 8'h5A, 0, 0);
    repeat (5) step(1, 0, 1, 8'h00, 1, 0);
    step(0, 1, 1, 8'h00, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    step(1, 0, 3, 8'hC3, 0, 0);
    repeat (6) step(1, 0, 2, 8'h00, 0, 1);
    aclr_pulse();
    repeat (2) step(1, 0, 1, 8'h00, 1, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    repeat (400) begin
      if ($urandom_range(0, 59) == 0) aclr_pulse();
      else step($urandom_range(0, 5) != 0, $urandom_range(0, 24) == 0, 2'($urandom_range(0, 3)),
                8'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (3) @(negedge clock);
    if (sb.size() != 0) chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
